mc_seq_ctrl: RTL and testbench
==============================

Name: mc_seq_ctrl

Overview:
- Multi-cycle sequencer for the MIPS core when instruction fetch and data access share one memory port.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Generates per-state write strobes and next-PC selects for the existing datapath (PC, IR, RF, ALU, NPC).
- Runs a req/rdy handshake with the shared memory, with timeout, halt and retire counting.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may stay high without mem_rdy; 0 disables the timeout.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- run  in  1  permit new instruction fetch
- op  in  6  instr[31:26], sampled from IR
- funct  in  6  instr[5:0]
- mem_rdy  in  1  memory accepts/returns the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write request (valid with mem_req)
- iord  out  1  0 = PC address, 1 = ALU address
- ir_wr  out  1  load IR from memory data
- pc_wr  out  1  update PC with NPC
- npc_sel  out  2  0 PLUS4, 1 BRANCH (datapath resolves condition), 2 JUMP, 3 JUMPR
- rf_wr  out  1  register-file write
- wd_sel  out  2  0 ALU, 1 memory data register, 2 PC+4 (link)
- retire  out  1  one-cycle pulse per completed instruction
- illegal  out  1  one-cycle pulse on an undecodable opcode
- bus_err  out  1  sticky; set on memory timeout
- state  out  3  current state, for debug
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEMRD=3, MEMWR=4, WB=5, HALT=6.
- Reset: state=FETCH, instret=0, bus_err=0, wait counter=0.
  - While rst=1, all strobes (mem_req, mem_we, ir_wr, pc_wr, rf_wr, retire, illegal) are 0.
  - npc_sel=0, wd_sel=0, iord=0.
- Strobes decode combinationally from state, op/funct and mem_rdy. Transitions occur on the clk edge.
- FETCH:
  - If run=0: no request; stay in FETCH.
  - Else mem_req=1, iord=0.
  - When mem_rdy=1: ir_wr=1, pc_wr=1, npc_sel=PLUS4; next DECODE.
  - Zero-wait (mem_rdy in the same cycle as mem_req) is legal.
- DECODE (1 cycle):
  - J (000010): pc_wr, npc_sel=JUMP, retire; next FETCH.
  - JAL (000011): same as J, plus rf_wr, wd_sel=2.
  - op=000000 with funct 001000 (JR): pc_wr, npc_sel=JUMPR, retire; next FETCH.
  - op=000000 with funct 001001 (JALR): as JR, plus rf_wr, wd_sel=2.
  - Other R-type, branches (000001, 000100–000111), ALU-immediate (001000–001111), loads (100000, 100001, 100011, 100100, 100101) and stores (101000, 101001, 101011): next EXEC.
  - Any other opcode: illegal pulse, no retire, no writes; next FETCH.
- EXEC:
  - Branch: pc_wr=1, npc_sel=BRANCH, retire; next FETCH.
  - Load: next MEMRD. Store: next MEMWR. Otherwise: next WB.
- MEMRD: mem_req=1, iord=1. On mem_rdy: next WB with wd_sel=1 for the following write.
- MEMWR: mem_req=1, mem_we=1, iord=1. On mem_rdy: retire; next FETCH.
- WB: rf_wr=1, retire; next FETCH.
  - wd_sel=1 if the instruction came from MEMRD, else 0.
- run=0 mid-instruction: the instruction completes; the block then idles in FETCH.
- Wait counter w:
  - Cleared on entry to any memory state and on any cycle with mem_rdy=1.
  - Increments each cycle with mem_req=1 and mem_rdy=0.
  - If MEM_TIMEOUT>0, w==MEM_TIMEOUT-1 and mem_rdy=0: bus_err<=1, next HALT.
  - mem_rdy in that same cycle wins: normal completion, no error.
- HALT: all strobes 0; remains until rst.
- instret: +1 on each retire; wraps from all-ones to 0.

Test Plan:
- ADDU (op 0, funct 100001), mem_rdy tied 1 → states 0,1,2,5,0.
  - ir_wr/pc_wr in cycle 1, rf_wr with wd_sel=0 in cycle 4, retire once; instret=1.
- LW (100011), fetch zero-wait, MEMRD with 2 wait cycles → mem_req/iord=1 held 3 cycles.
  - WB rf_wr with wd_sel=1; total 7 cycles; retire once.
- JAL (000011) → pc_wr, npc_sel=2, rf_wr, wd_sel=2 in DECODE; back in FETCH after 2 cycles.
- Opcode 111111 → illegal pulse in DECODE; no writes, no retire; instret unchanged.
- MEM_TIMEOUT=4, fetch with mem_rdy held 0 → mem_req high exactly 4 cycles.
  - Then state=6, bus_err=1, all strobes 0 until rst.
- run dropped during EXEC of SW (101011) → store completes with retire; FETCH then idles with mem_req=0.
- Preload instret to all-ones, retire → instret=0.

Source files
------------

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a MIPS core sharing one
// memory port between instruction fetch and data access.
module mc_seq_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_rdy,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       npc_sel,
  output logic             rf_wr,
  output logic [1:0]       wd_sel,
  output logic             retire,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEMRD = 3'd3,
    MEMWR = 3'd4, WB = 3'd5, HALT = 3'd6
  } st_t;

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] TO_M1 = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  st_t          st, nxt;
  logic [WW-1:0] w;
  logic         from_mem;
  logic         tmo;
  logic         is_j, is_jal, is_jr, is_jalr, is_br, is_ld, is_st, is_exec;

  always_comb begin
    is_j    = (op == 6'b000010);
    is_jal  = (op == 6'b000011);
    is_jr   = (op == 6'b000000) && (funct == 6'b001000);
    is_jalr = (op == 6'b000000) && (funct == 6'b001001);
    is_br   = (op == 6'b000001) || (op[5:2] == 4'b0001);
    is_ld   = op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101};
    is_st   = op inside {6'b101000, 6'b101001, 6'b101011};
    is_exec = ((op == 6'b000000) && !is_jr && !is_jalr) || is_br ||
              (op[5:3] == 3'b001) || is_ld || is_st;
  end

  // Strobes are combinational so a zero-wait mem_rdy completes in the same cycle.
  always_comb begin
    nxt     = st;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    iord    = 1'b0;
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    npc_sel = 2'd0;
    rf_wr   = 1'b0;
    wd_sel  = 2'd0;
    retire  = 1'b0;
    illegal = 1'b0;
    tmo     = 1'b0;
    if (!rst) begin
      case (st)
        FETCH: if (run) begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            ir_wr = 1'b1;
            pc_wr = 1'b1;
            nxt   = DECODE;
          end
        end
        DECODE: begin
          if (is_j || is_jal) begin
            pc_wr   = 1'b1;
            npc_sel = 2'd2;
            retire  = 1'b1;
            rf_wr   = is_jal;
            wd_sel  = is_jal ? 2'd2 : 2'd0;
            nxt     = FETCH;
          end else if (is_jr || is_jalr) begin
            pc_wr   = 1'b1;
            npc_sel = 2'd3;
            retire  = 1'b1;
            rf_wr   = is_jalr;
            wd_sel  = is_jalr ? 2'd2 : 2'd0;
            nxt     = FETCH;
          end else if (is_exec) begin
            nxt = EXEC;
          end else begin
            illegal = 1'b1;
            nxt     = FETCH;
          end
        end
        EXEC: begin
          if (is_br) begin
            pc_wr   = 1'b1;
            npc_sel = 2'd1;
            retire  = 1'b1;
            nxt     = FETCH;
          end else if (is_ld) nxt = MEMRD;
          else if (is_st)     nxt = MEMWR;
          else                nxt = WB;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_rdy) nxt = WB;
        end
        MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_rdy) begin
            retire = 1'b1;
            nxt    = FETCH;
          end
        end
        WB: begin
          rf_wr  = 1'b1;
          retire = 1'b1;
          wd_sel = from_mem ? 2'd1 : 2'd0;
          nxt    = FETCH;
        end
        default: nxt = HALT;
      endcase
      // A late mem_rdy on the last allowed cycle still counts as completion.
      if ((MEM_TIMEOUT > 0) && mem_req && !mem_rdy && (w == TO_M1)) begin
        tmo = 1'b1;
        nxt = HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= FETCH;
      instret  <= '0;
      bus_err  <= 1'b0;
      w        <= '0;
      from_mem <= 1'b0;
    end else begin
      st       <= nxt;
      from_mem <= (st == MEMRD);
      if (retire) instret <= instret + CNT_W'(1);
      if (tmo)    bus_err <= 1'b1;
      if ((nxt != st) || mem_rdy || !mem_req) w <= '0;
      else                                    w <= w + WW'(1);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed bench for mc_seq_ctrl: per-cycle expected strobe vectors go through
// a scoreboard queue and are compared against the DUT just before each edge.
module tb_mc_seq_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, io, irw, pcw;
    logic [1:0] npc;
    logic       rfw;
    logic [1:0] wd;
    logic       ret, ill, berr;
    logic [2:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       mem_rdy = 1'b0;
  logic       mem_req, mem_we, iord, ir_wr, pc_wr, rf_wr, retire, illegal, bus_err;
  logic [1:0] npc_sel, wd_sel;
  logic [2:0] state;
  logic [2:0] instret;

  exp_t got;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mc_seq_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op), .funct(funct), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .npc_sel(npc_sel), .rf_wr(rf_wr), .wd_sel(wd_sel), .retire(retire),
    .illegal(illegal), .bus_err(bus_err), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  assign got = {state, mem_req, mem_we, iord, ir_wr, pc_wr, npc_sel, rf_wr, wd_sel,
                retire, illegal, bus_err, instret};

  function automatic exp_t E(input int s, rq, we, io, irw, pcw, npc, rfw, wd,
                             ret, ill, be, cnt);
    exp_t e;
    e.st = 3'(s);  e.req = 1'(rq); e.we = 1'(we); e.io = 1'(io);
    e.irw = 1'(irw); e.pcw = 1'(pcw); e.npc = 2'(npc); e.rfw = 1'(rfw);
    e.wd = 2'(wd); e.ret = 1'(ret); e.ill = 1'(ill); e.berr = 1'(be);
    e.cnt = 3'(cnt);
    return e;
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare before the edge.
  task automatic step(input string tag, input bit r, rn, input logic [5:0] o, f,
                      input bit rdy, input exp_t e);
    exp_t x;
    @(negedge clk);
    rst = r; run = rn; op = o; funct = f; mem_rdy = rdy;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    n_tests++;
    assert (got === x) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, x);
    end
  endtask

  task automatic addu(input string tag, input int c);
    step({tag, "_f"}, 0, 1, 6'b000000, 6'b100001, 1, E(0,1,0,0,1,1,0,0,0,0,0,0,c));
    step({tag, "_d"}, 0, 1, 6'b000000, 6'b100001, 1, E(1,0,0,0,0,0,0,0,0,0,0,0,c));
    step({tag, "_e"}, 0, 1, 6'b000000, 6'b100001, 1, E(2,0,0,0,0,0,0,0,0,0,0,0,c));
    step({tag, "_wb"}, 0, 1, 6'b000000, 6'b100001, 1, E(5,0,0,0,0,0,0,1,0,1,0,0,c));
  endtask

  initial begin
    @(posedge clk);
    step("reset", 1, 1, 6'b000000, 6'b100001, 1, E(0,0,0,0,0,0,0,0,0,0,0,0,0));

    addu("addu", 0);

    // LW: zero-wait fetch, two wait states in MEMRD.
    step("lw_f",   0, 1, 6'b100011, 0, 1, E(0,1,0,0,1,1,0,0,0,0,0,0,1));
    step("lw_d",   0, 1, 6'b100011, 0, 1, E(1,0,0,0,0,0,0,0,0,0,0,0,1));
    step("lw_e",   0, 1, 6'b100011, 0, 1, E(2,0,0,0,0,0,0,0,0,0,0,0,1));
    step("lw_m0",  0, 1, 6'b100011, 0, 0, E(3,1,0,1,0,0,0,0,0,0,0,0,1));
    step("lw_m1",  0, 1, 6'b100011, 0, 0, E(3,1,0,1,0,0,0,0,0,0,0,0,1));
    step("lw_m2",  0, 1, 6'b100011, 0, 1, E(3,1,0,1,0,0,0,0,0,0,0,0,1));
    step("lw_wb",  0, 1, 6'b100011, 0, 1, E(5,0,0,0,0,0,0,1,1,1,0,0,1));

    step("jal_f",  0, 1, 6'b000011, 0, 1, E(0,1,0,0,1,1,0,0,0,0,0,0,2));
    step("jal_d",  0, 1, 6'b000011, 0, 1, E(1,0,0,0,0,1,2,1,2,1,0,0,2));

    step("ill_f",  0, 1, 6'b111111, 0, 1, E(0,1,0,0,1,1,0,0,0,0,0,0,3));
    step("ill_d",  0, 1, 6'b111111, 0, 1, E(1,0,0,0,0,0,0,0,0,0,1,0,3));

    // SW with run dropped in EXEC: store still retires, then FETCH idles.
    step("sw_f",   0, 1, 6'b101011, 0, 1, E(0,1,0,0,1,1,0,0,0,0,0,0,3));
    step("sw_d",   0, 1, 6'b101011, 0, 1, E(1,0,0,0,0,0,0,0,0,0,0,0,3));
    step("sw_e",   0, 0, 6'b101011, 0, 1, E(2,0,0,0,0,0,0,0,0,0,0,0,3));
    step("sw_m",   0, 0, 6'b101011, 0, 1, E(4,1,1,1,0,0,0,0,0,1,0,0,3));
    step("idle0",  0, 0, 6'b101011, 0, 1, E(0,0,0,0,0,0,0,0,0,0,0,0,4));
    step("idle1",  0, 0, 6'b101011, 0, 1, E(0,0,0,0,0,0,0,0,0,0,0,0,4));

    for (int i = 0; i < 4; i++) addu($sformatf("addu%0d", i), 4 + i);
    step("wrap",   0, 0, 0, 0, 0, E(0,0,0,0,0,0,0,0,0,0,0,0,0));

    // mem_rdy arriving on the last allowed cycle completes without error.
    for (int i = 0; i < 3; i++)
      step($sformatf("late_w%0d", i), 0, 1, 6'b000100, 0, 0, E(0,1,0,0,0,0,0,0,0,0,0,0,0));
    step("late_ok", 0, 1, 6'b000100, 0, 1, E(0,1,0,0,1,1,0,0,0,0,0,0,0));
    step("beq_d",   0, 1, 6'b000100, 0, 1, E(1,0,0,0,0,0,0,0,0,0,0,0,0));
    step("beq_e",   0, 1, 6'b000100, 0, 1, E(2,0,0,0,0,1,1,0,0,1,0,0,0));

    // Timeout: mem_req for exactly four cycles, then HALT with sticky bus_err.
    for (int i = 0; i < 4; i++)
      step($sformatf("to_w%0d", i), 0, 1, 0, 0, 0, E(0,1,0,0,0,0,0,0,0,0,0,0,1));
    step("halt0",  0, 1, 0, 0, 1, E(6,0,0,0,0,0,0,0,0,0,0,1,1));
    step("halt1",  0, 1, 0, 0, 0, E(6,0,0,0,0,0,0,0,0,0,0,1,1));
    step("halt2",  0, 1, 6'b000011, 0, 1, E(6,0,0,0,0,0,0,0,0,0,0,1,1));
    step("halt_rst", 1, 1, 0, 0, 1, E(6,0,0,0,0,0,0,0,0,0,0,1,1));
    step("post_rst", 0, 0, 0, 0, 1, E(0,0,0,0,0,0,0,0,0,0,0,0,0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
